// File: rtl/imm_gen_pipe.sv
// Purpose: decode RV32I/RV64I immediates (I/S/B/U/J, optional Z), sign-extend to XLEN, precompute pc+imm.
// Latency: 1 cycle; an instruction accepted at edge N is presented on out_* during cycle N+1.
// Backpressure: main register plus one skid entry; in_ready is a flop (low while skid full), no comb ready path.
// Optional feature: define IMM_GEN_ZICSR_EN to decode CSR-immediate forms (opcode 1110011, funct3[2]=1) as fmt Z.
module imm_gen_pipe #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [XLEN-1:0] in_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_imm,
   output logic [2:0]      out_fmt,
   output logic [XLEN-1:0] out_target,
   output logic [XLEN-1:0] out_pc,
   output logic            out_illegal
);

   typedef enum logic [2:0] {
      FMT_NONE = 3'd0,
      FMT_I    = 3'd1,
      FMT_S    = 3'd2,
      FMT_B    = 3'd3,
      FMT_U    = 3'd4,
      FMT_J    = 3'd5,
      FMT_Z    = 3'd6
   } fmt_e;

   // One decoded instruction as held in the main or skid register.
   typedef struct packed {
      logic [XLEN-1:0] imm;
      logic [XLEN-1:0] target;
      logic [XLEN-1:0] pc;
      fmt_e            fmt;
      logic            illegal;
   } entry_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_IMM32  = 7'b0011011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_OP32   = 7'b0111011;

   fmt_e            dec_fmt;
   logic            dec_ill;
   logic [XLEN-1:0] dec_imm;
   entry_t          dec_entry;

   entry_t main_q, main_d;
   entry_t skid_q, skid_d;
   logic   main_vld_q, main_vld_d;
   logic   skid_vld_q, skid_vld_d;
   logic   in_ready_q, in_ready_d;

   logic   accept;
   logic   xfer;

   // Classify the opcode into an immediate format; anything unrecognised is flagged illegal.
   always_comb begin
      dec_fmt = FMT_NONE;
      dec_ill = 1'b0;
      case (in_instr[6:0])
         OP_LOAD, OP_IMM, OP_JALR: dec_fmt = FMT_I;
         OP_SYSTEM: begin
`ifdef IMM_GEN_ZICSR_EN
            dec_fmt = in_instr[14] ? FMT_Z : FMT_I;
`else
            dec_fmt = FMT_I;
`endif
         end
         OP_IMM32: begin
            if (XLEN == 64) dec_fmt = FMT_I;
            else            dec_ill = 1'b1;
         end
         OP_STORE:         dec_fmt = FMT_S;
         OP_BRANCH:        dec_fmt = FMT_B;
         OP_LUI, OP_AUIPC: dec_fmt = FMT_U;
         OP_JAL:           dec_fmt = FMT_J;
         OP_OP:            dec_fmt = FMT_NONE;
         OP_OP32: begin
            if (XLEN != 64) dec_ill = 1'b1;
         end
         default:          dec_ill = 1'b1;
      endcase
   end

   // Assemble the immediate: fill with the sign bit, then overwrite the low field bits.
   always_comb begin
      dec_imm = '0;
      case (dec_fmt)
         FMT_I: begin
            dec_imm        = {XLEN{in_instr[31]}};
            dec_imm[11:0]  = in_instr[31:20];
         end
         FMT_S: begin
            dec_imm        = {XLEN{in_instr[31]}};
            dec_imm[11:0]  = {in_instr[31:25], in_instr[11:7]};
         end
         FMT_B: begin
            dec_imm        = {XLEN{in_instr[31]}};
            dec_imm[12:0]  = {in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
         end
         FMT_U: begin
            dec_imm        = {XLEN{in_instr[31]}};
            dec_imm[31:0]  = {in_instr[31:12], 12'b0};
         end
         FMT_J: begin
            dec_imm        = {XLEN{in_instr[31]}};
            dec_imm[20:0]  = {in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
         end
`ifdef IMM_GEN_ZICSR_EN
         FMT_Z: begin
            dec_imm[4:0]   = in_instr[19:15];
         end
`endif
         default: dec_imm = '0;
      endcase
   end

   // Pack the decoded fields; the target adds in XLEN bits so the carry out is dropped.
   always_comb begin
      dec_entry         = '0;
      dec_entry.imm     = dec_imm;
      dec_entry.target  = in_pc + dec_imm;
      dec_entry.pc      = in_pc;
      dec_entry.fmt     = dec_fmt;
      dec_entry.illegal = dec_ill;
   end

   assign accept = in_valid && in_ready_q;
   assign xfer   = main_vld_q && out_ready;

   // Main/skid steering. in_ready is only high with the skid empty, so an accept never hits a full skid.
   always_comb begin
      main_d     = main_q;
      skid_d     = skid_q;
      main_vld_d = main_vld_q;
      skid_vld_d = skid_vld_q;
      if (flush) begin
         main_vld_d = 1'b0;
         skid_vld_d = 1'b0;
      end else begin
         if (xfer) begin
            if (skid_vld_q) begin
               main_d     = skid_q;
               skid_vld_d = 1'b0;
            end else begin
               main_vld_d = 1'b0;
            end
         end
         if (accept) begin
            if (!main_vld_q || xfer) begin
               main_d     = dec_entry;
               main_vld_d = 1'b1;
            end else begin
               skid_d     = dec_entry;
               skid_vld_d = 1'b1;
            end
         end
      end
      in_ready_d = !skid_vld_d;
   end

   // State registers; reset clears every held entry and zeroes the visible outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_q     <= '0;
         skid_q     <= '0;
         main_vld_q <= 1'b0;
         skid_vld_q <= 1'b0;
         in_ready_q <= 1'b1;
      end else begin
         main_q     <= main_d;
         skid_q     <= skid_d;
         main_vld_q <= main_vld_d;
         skid_vld_q <= skid_vld_d;
         in_ready_q <= in_ready_d;
      end
   end

   assign in_ready    = in_ready_q;
   assign out_valid   = main_vld_q;
   assign out_imm     = main_q.imm;
   assign out_target  = main_q.target;
   assign out_pc      = main_q.pc;
   assign out_fmt     = main_q.fmt;
   assign out_illegal = main_q.illegal;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances driven in lockstep.
// Stimulus pushes hand-computed expectations; a negedge monitor pops them on every transfer.
// Covers reset, all formats, illegal opcodes, backpressure/skid, flush and mid-stream reset.
module tb_imm_gen_pipe;

   logic        clk;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic [31:0] in_instr;
   logic [31:0] in_pc;
   logic [63:0] in_pc64;
   logic        out_ready;

   logic        in_ready32, out_valid32, out_illegal32;
   logic [2:0]  out_fmt32;
   logic [31:0] out_imm32, out_target32, out_pc32;

   logic        in_ready64, out_valid64, out_illegal64;
   logic [2:0]  out_fmt64;
   logic [63:0] out_imm64, out_target64, out_pc64;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic [63:0] imm;
      logic [63:0] tgt;
      logic [63:0] pc;
      logic [2:0]  fmt;
      logic        ill;
   } exp_t;

   exp_t q32[$];
   exp_t q64[$];

   assign in_pc64 = {32'h0, in_pc};

   imm_gen_pipe #(.XLEN(32)) u_dut32 (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready32), .in_instr(in_instr), .in_pc(in_pc),
      .out_valid(out_valid32), .out_ready(out_ready), .out_imm(out_imm32), .out_fmt(out_fmt32),
      .out_target(out_target32), .out_pc(out_pc32), .out_illegal(out_illegal32)
   );

   imm_gen_pipe #(.XLEN(64)) u_dut64 (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready64), .in_instr(in_instr), .in_pc(in_pc64),
      .out_valid(out_valid64), .out_ready(out_ready), .out_imm(out_imm64), .out_fmt(out_fmt64),
      .out_target(out_target64), .out_pc(out_pc64), .out_illegal(out_illegal64)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every transfer must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rst_n && out_ready) begin
         if (out_valid32) begin
            tests++;
            if (q32.size() == 0) begin
               fails++;
               $display("FAIL out32: unexpected output pc=%h", out_pc32);
            end else begin
               exp_t e;
               e = q32.pop_front();
               if ({out_imm32, out_target32, out_pc32, out_fmt32, out_illegal32} !==
                   {e.imm[31:0], e.tgt[31:0], e.pc[31:0], e.fmt, e.ill}) begin
                  fails++;
                  $display("FAIL out32: got imm=%h tgt=%h pc=%h fmt=%0d ill=%b expected imm=%h tgt=%h pc=%h fmt=%0d ill=%b",
                           out_imm32, out_target32, out_pc32, out_fmt32, out_illegal32,
                           e.imm[31:0], e.tgt[31:0], e.pc[31:0], e.fmt, e.ill);
               end
            end
         end
         if (out_valid64) begin
            tests++;
            if (q64.size() == 0) begin
               fails++;
               $display("FAIL out64: unexpected output pc=%h", out_pc64);
            end else begin
               exp_t e;
               e = q64.pop_front();
               if ({out_imm64, out_target64, out_pc64, out_fmt64, out_illegal64} !==
                   {e.imm, e.tgt, e.pc, e.fmt, e.ill}) begin
                  fails++;
                  $display("FAIL out64: got imm=%h tgt=%h pc=%h fmt=%0d ill=%b expected imm=%h tgt=%h pc=%h fmt=%0d ill=%b",
                           out_imm64, out_target64, out_pc64, out_fmt64, out_illegal64,
                           e.imm, e.tgt, e.pc, e.fmt, e.ill);
               end
            end
         end
      end
   end

   // Present one instruction, wait (bounded) for acceptance, and record both expectations.
   task automatic send(input logic [31:0] instr, input logic [31:0] pc,
                       input logic [31:0] imm32, input logic [2:0] fmt32, input logic ill32,
                       input logic [63:0] imm64, input logic [2:0] fmt64, input logic ill64);
      exp_t e32, e64;
      int   n;
      in_valid = 1'b1;
      in_instr = instr;
      in_pc    = pc;
      n = 0;
      forever begin
         @(negedge clk);
         if (in_ready32 && in_ready64) break;
         n++;
         if (n > 50) break;
      end
      if (n > 50) begin
         tests++;
         fails++;
         $display("FAIL accept: instr %h never accepted", instr);
         in_valid = 1'b0;
      end else begin
         e32.imm = {32'h0, imm32};
         e32.tgt = {32'h0, pc + imm32};
         e32.pc  = {32'h0, pc};
         e32.fmt = fmt32;
         e32.ill = ill32;
         e64.imm = imm64;
         e64.tgt = {32'h0, pc} + imm64;
         e64.pc  = {32'h0, pc};
         e64.fmt = fmt64;
         e64.ill = ill64;
         q32.push_back(e32);
         q64.push_back(e64);
         @(posedge clk);
         #1;
         in_valid = 1'b0;
      end
   endtask

   // Same decode in both widths; the 64-bit immediate is the sign extension of the 32-bit one.
   task automatic sendc(input logic [31:0] instr, input logic [31:0] pc,
                        input logic [31:0] imm32, input logic [2:0] fmt, input logic ill);
      send(instr, pc, imm32, fmt, ill, {{32{imm32[31]}}, imm32}, fmt, ill);
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while ((q32.size() != 0 || q64.size() != 0) && n < 100) begin
         @(posedge clk);
         n++;
      end
      #1;
      tests++;
      if (q32.size() != 0 || q64.size() != 0) begin
         fails++;
         $display("FAIL %s: %0d/%0d entries never emerged, expected 0", name, q32.size(), q64.size());
      end
   endtask

   task automatic chk_zero(input string name);
      chk({name, "_valid32"}, {63'h0, out_valid32}, 64'h0);
      chk({name, "_valid64"}, {63'h0, out_valid64}, 64'h0);
      chk({name, "_ready32"}, {63'h0, in_ready32}, 64'h1);
      chk({name, "_ready64"}, {63'h0, in_ready64}, 64'h1);
      chk({name, "_data32"}, {out_imm32, out_target32} | {out_pc32, 25'h0, out_fmt32, out_illegal32}, 64'h0);
      chk({name, "_data64"}, out_imm64 | out_target64 | out_pc64 | {60'h0, out_fmt64, out_illegal64}, 64'h0);
   endtask

   initial begin
      rst_n     = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_instr  = 32'h0;
      in_pc     = 32'h0;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk_zero("rst");
      rst_n = 1'b1;
      @(negedge clk);
      chk_zero("post_rst");
      @(posedge clk);
      #1;

      // Streaming, out_ready held high.
      sendc(32'hFFC12083, 32'h100, 32'hFFFFFFFC, 3'd1, 1'b0);            // lw
      sendc(32'hFE112E23, 32'h100, 32'hFFFFFFFC, 3'd2, 1'b0);            // sw
      sendc(32'hFE000CE3, 32'h100, 32'hFFFFFFF8, 3'd3, 1'b0);            // beq -8
      sendc(32'h123452B7, 32'h100, 32'h12345000, 3'd4, 1'b0);            // lui
      sendc(32'h800002B7, 32'h100, 32'h80000000, 3'd4, 1'b0);            // lui, top bit set
      sendc(32'h00000000, 32'h100, 32'h00000000, 3'd0, 1'b1);            // all-zero word
      sendc(32'h0080006F, 32'h100, 32'h00000008, 3'd5, 1'b0);            // jal +8
      sendc(32'hFFDFF0EF, 32'h100, 32'hFFFFFFFC, 3'd5, 1'b0);            // jal -4
      send (32'h0010809B, 32'h100, 32'h0, 3'd0, 1'b1, 64'h1, 3'd1, 1'b0); // addiw
      sendc(32'h002080B3, 32'h100, 32'h00000000, 3'd0, 1'b0);            // add
      send (32'h002080BB, 32'h100, 32'h0, 3'd0, 1'b1, 64'h0, 3'd0, 1'b0); // addw
      sendc(32'hFFFFF117, 32'h2000, 32'hFFFFF000, 3'd4, 1'b0);           // auipc, carry dropped
      sendc(32'h000080E7, 32'h100, 32'h00000000, 3'd1, 1'b0);            // jalr
      sendc(32'h00000012, 32'h100, 32'h00000000, 3'd0, 1'b1);            // instr[1:0] != 11
      sendc(32'h00209093, 32'h100, 32'h00000002, 3'd1, 1'b0);            // slli
      sendc(32'h4020D093, 32'h100, 32'h00000402, 3'd1, 1'b0);            // srai, no shamt mask
      sendc(32'h0080006F, 32'hFFFFFFFC, 32'h00000008, 3'd5, 1'b0);       // target wraps at 32 bits
`ifdef IMM_GEN_ZICSR_EN
      sendc(32'h3405D073, 32'h100, 32'h0000000B, 3'd6, 1'b0);            // csrrwi as Z
`else
      sendc(32'h3405D073, 32'h100, 32'h00000340, 3'd1, 1'b0);            // csrrwi as I
`endif
      drain("drain_stream");

      // Backpressure: two entries held, third waits for space.
      out_ready = 1'b0;
      sendc(32'h00500093, 32'h200, 32'h00000005, 3'd1, 1'b0);
      sendc(32'h00600093, 32'h204, 32'h00000006, 3'd1, 1'b0);
      @(negedge clk);
      chk("bp_ready32", {63'h0, in_ready32}, 64'h0);
      chk("bp_ready64", {63'h0, in_ready64}, 64'h0);
      chk("bp_valid32", {63'h0, out_valid32}, 64'h1);
      chk("bp_hold_pc32", {32'h0, out_pc32}, 64'h200);
      @(posedge clk);
      #1;
      fork
         sendc(32'h00700093, 32'h208, 32'h00000007, 3'd1, 1'b0);
         begin
            repeat (3) @(posedge clk);
            @(negedge clk);
            chk("bp_stable_pc64", out_pc64, 64'h200);
            chk("bp_stable_imm32", {32'h0, out_imm32}, 64'h5);
            @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      drain("drain_bp");

      // Flush with two entries held.
      out_ready = 1'b0;
      sendc(32'h00100093, 32'h300, 32'h00000001, 3'd1, 1'b0);
      sendc(32'h00200093, 32'h304, 32'h00000002, 3'd1, 1'b0);
      flush    = 1'b1;
      in_valid = 1'b1;
      in_instr = 32'h00300093;
      in_pc    = 32'h308;
      @(posedge clk);
      #1;
      flush    = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      chk("flush_valid32", {63'h0, out_valid32}, 64'h0);
      chk("flush_valid64", {63'h0, out_valid64}, 64'h0);
      chk("flush_ready32", {63'h0, in_ready32}, 64'h1);
      q32.delete();
      q64.delete();
      // Input offered with in_ready high during a flush is dropped.
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      flush     = 1'b1;
      in_valid  = 1'b1;
      in_instr  = 32'h00400093;
      in_pc     = 32'h30C;
      @(posedge clk);
      #1;
      flush    = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      chk("flush_drop32", {63'h0, out_valid32}, 64'h0);
      chk("flush_drop64", {63'h0, out_valid64}, 64'h0);
      @(posedge clk);
      #1;
      sendc(32'hFFF00093, 32'h310, 32'hFFFFFFFF, 3'd1, 1'b0);
      drain("drain_flush");

      // Asynchronous reset mid-cycle with two entries held.
      out_ready = 1'b0;
      sendc(32'h00A00093, 32'h400, 32'h0000000A, 3'd1, 1'b0);
      sendc(32'h00B00093, 32'h404, 32'h0000000B, 3'd1, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      chk_zero("midrst");
      q32.delete();
      q64.delete();
      @(negedge clk);
      rst_n     = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      @(negedge clk);
      chk("midrst_empty32", {63'h0, out_valid32}, 64'h0);
      @(posedge clk);
      #1;
      sendc(32'h0080006F, 32'h500, 32'h00000008, 3'd5, 1'b0);
      drain("drain_rst");

      repeat (3) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
